// File: rtl/mjpg_stream_parser.sv
// Receive-side MJPG parser: delimits frames at SOI/EOI, captures SOF0 size, skips headers, unstuffs ECS.
// Every output is registered (one cycle after the accepting byte); state only advances on jvalid cycles.
module mjpg_stream_parser #(
  parameter int FRAME_CNT_W = 16,
  parameter bit PASS_RST    = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jvalid,
  input  logic [7:0]             jpeg,
  output logic                   ecs_valid,
  output logic [7:0]             ecs_data,
  output logic                   ecs_rst,
  output logic                   frame_start,
  output logic                   frame_end,
  output logic                   hdr_valid,
  output logic [15:0]            width,
  output logic [15:0]            height,
  output logic                   err,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  typedef enum logic [3:0] {
    HUNT, HUNT_FF, MARK, MARK_FF, LEN_H, LEN_L, BODY, ECS, ECS_FF
  } state_t;

  state_t      state;
  logic [7:0]  mcode;
  logic [7:0]  len_hi;
  logic [15:0] cnt;
  logic [15:0] h_tmp;
  logic [15:0] w_tmp;
  logic [2:0]  idx;
  logic [15:0] seg_len;
  logic        is_rstn;

  assign seg_len = {len_hi, jpeg};
  assign is_rstn = (jpeg[7:3] == 5'b11010);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      mcode       <= 8'h00;
      len_hi      <= 8'h00;
      cnt         <= 16'd0;
      h_tmp       <= 16'd0;
      w_tmp       <= 16'd0;
      idx         <= 3'd0;
      ecs_valid   <= 1'b0;
      ecs_data    <= 8'h00;
      ecs_rst     <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      hdr_valid   <= 1'b0;
      width       <= 16'd0;
      height      <= 16'd0;
      err         <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      ecs_valid   <= 1'b0;
      ecs_rst     <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      hdr_valid   <= 1'b0;
      err         <= 1'b0;
      if (jvalid) begin
        case (state)
          HUNT: if (jpeg == 8'hFF) state <= HUNT_FF;
          HUNT_FF: begin
            if (jpeg == 8'hD8) begin
              frame_start <= 1'b1;
              state       <= MARK;
            end else if (jpeg != 8'hFF) begin
              state <= HUNT;
            end
          end
          MARK: begin
            if (jpeg == 8'hFF) state <= MARK_FF;
            else begin
              err   <= 1'b1;
              state <= HUNT;
            end
          end
          MARK_FF: begin
            mcode <= jpeg;
            if (jpeg == 8'hFF) begin
              state <= MARK_FF;
            end else if (jpeg == 8'hD9) begin
              frame_end <= 1'b1;
              frame_cnt <= frame_cnt + 1'b1;
              state     <= HUNT;
            end else if (jpeg == 8'hD8) begin
              err         <= 1'b1;
              frame_start <= 1'b1;
              state       <= MARK;
            end else if (jpeg == 8'h01 || is_rstn) begin
              state <= MARK;
            end else if (jpeg == 8'h00) begin
              err   <= 1'b1;
              state <= HUNT;
            end else begin
              state <= LEN_H;
            end
          end
          LEN_H: begin
            len_hi <= jpeg;
            state  <= LEN_L;
          end
          LEN_L: begin
            cnt <= seg_len - 16'd2;
            idx <= 3'd0;
            if (seg_len < 16'd2) begin
              err   <= 1'b1;
              state <= HUNT;
            end else if (seg_len == 16'd2) begin
              // Empty body: an empty SOF0 is as short as a SOF0 can get.
              if (mcode == 8'hC0) begin
                err   <= 1'b1;
                state <= HUNT;
              end else if (mcode == 8'hDA) state <= ECS;
              else state <= MARK;
            end else begin
              state <= BODY;
            end
          end
          BODY: begin
            cnt <= cnt - 16'd1;
            if (idx != 3'd7) idx <= idx + 3'd1;
            case (idx)
              3'd1:    h_tmp[15:8] <= jpeg;
              3'd2:    h_tmp[7:0]  <= jpeg;
              3'd3:    w_tmp[15:8] <= jpeg;
              3'd4:    w_tmp[7:0]  <= jpeg;
              default: ;
            endcase
            if (cnt == 16'd1) begin
              if (mcode == 8'hC0) begin
                // Last byte may itself be width[7:0], so bypass the staging register.
                if (idx >= 3'd4) begin
                  hdr_valid <= 1'b1;
                  height    <= h_tmp;
                  width     <= (idx == 3'd4) ? {w_tmp[15:8], jpeg} : w_tmp;
                  state     <= MARK;
                end else begin
                  err   <= 1'b1;
                  state <= HUNT;
                end
              end else if (mcode == 8'hDA) state <= ECS;
              else state <= MARK;
            end
          end
          ECS: begin
            if (jpeg == 8'hFF) state <= ECS_FF;
            else begin
              ecs_valid <= 1'b1;
              ecs_data  <= jpeg;
            end
          end
          ECS_FF: begin
            if (jpeg == 8'h00) begin
              ecs_valid <= 1'b1;
              ecs_data  <= 8'hFF;
              state     <= ECS;
            end else if (is_rstn) begin
              ecs_rst <= PASS_RST;
              state   <= ECS;
            end else if (jpeg == 8'hD9) begin
              frame_end <= 1'b1;
              frame_cnt <= frame_cnt + 1'b1;
              state     <= HUNT;
            end else if (jpeg != 8'hFF) begin
              err   <= 1'b1;
              state <= HUNT;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mjpg_stream_parser.sv
// Bench for mjpg_stream_parser: two instances (RSTn dropped / RSTn passed with a 2-bit frame counter)
// share one byte stream; a segment-level stream model supplies the expected events.
module tb_mjpg_stream_parser;
  typedef logic [7:0] u8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic jvalid = 1'b0;
  logic [7:0] jpeg = 8'h00;
  always #5 clk = ~clk;

  logic e0_v, r0, fs0, fe0, hv0, er0;
  logic [7:0] e0_d;
  logic [15:0] w0, h0, fc0;
  logic e1_v, r1, fs1, fe1, hv1, er1;
  logic [7:0] e1_d;
  logic [15:0] w1, h1;
  logic [1:0] fc1;

  mjpg_stream_parser #(.FRAME_CNT_W(16), .PASS_RST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .jvalid(jvalid), .jpeg(jpeg),
    .ecs_valid(e0_v), .ecs_data(e0_d), .ecs_rst(r0), .frame_start(fs0), .frame_end(fe0),
    .hdr_valid(hv0), .width(w0), .height(h0), .err(er0), .frame_cnt(fc0));

  mjpg_stream_parser #(.FRAME_CNT_W(2), .PASS_RST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .jvalid(jvalid), .jpeg(jpeg),
    .ecs_valid(e1_v), .ecs_data(e1_d), .ecs_rst(r1), .frame_start(fs1), .frame_end(fe1),
    .hdr_valid(hv1), .width(w1), .height(h1), .err(er1), .frame_cnt(fc1));

  int n_vec = 0;
  int n_bad = 0;

  u8 stim[$];
  u8 m_ecs[$];
  u8 got0[$];
  u8 got1[$];
  int m_fs, m_fe, m_hdr, m_err, m_rst, m_cnt;
  logic [15:0] m_w, m_h;

  int c_fs = 0, c_fe = 0, c_hdr = 0, c_err = 0, c_rst0 = 0, c_rst1 = 0, c_clash = 0, c_diff = 0;
  int b_fs, b_fe, b_hdr, b_err, b_rst0, b_rst1, b_clash, b_diff, b_g0, b_g1;

  always @(negedge clk) begin
    if (e0_v) got0.push_back(e0_d);
    if (e1_v) got1.push_back(e1_d);
    c_fs   += int'(fs0);
    c_fe   += int'(fe0);
    c_hdr  += int'(hv0);
    c_err  += int'(er0);
    c_rst0 += int'(r0);
    c_rst1 += int'(r1);
    c_clash += int'(er0 & fe0);
    if (fs0 != fs1 || fe0 != fe1 || hv0 != hv1 || er0 != er1 || e0_v != e1_v ||
        (e0_v && e0_d != e1_d) || w0 != w1 || h0 != h1)
      c_diff++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    jvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_w = 16'd0;
    m_h = 16'd0;
    m_cnt = 0;
  endtask

  task automatic send(input u8 b);
    jvalid = 1'b1;
    jpeg = b;
    @(negedge clk);
    jvalid = 1'b0;
  endtask

  task automatic play(input int gmax);
    foreach (stim[k]) begin
      send(stim[k]);
      if (gmax > 0) repeat ($urandom_range(1, gmax)) @(negedge clk);
    end
  endtask

  task automatic flush();
    jvalid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Walks the stream segment by segment: hunt for SOI, then marker/length-skipped segments, then ECS.
  task automatic run_model();
    int i, n, mode, len;
    u8 b, m;
    bit done;
    i = 0; n = stim.size(); mode = 0; done = 0;
    m_ecs.delete();
    m_fs = 0; m_fe = 0; m_hdr = 0; m_err = 0; m_rst = 0;
    while (!done) begin
      if (i >= n) done = 1;
      else if (mode == 0) begin
        if (stim[i] != 8'hFF) i++;
        else begin
          i++;
          while (i < n && stim[i] == 8'hFF) i++;
          if (i < n) begin
            b = stim[i]; i++;
            if (b == 8'hD8) begin m_fs++; mode = 1; end
          end
        end
      end else if (mode == 1) begin
        if (stim[i] != 8'hFF) begin m_err++; i++; mode = 0; end
        else begin
          i++;
          while (i < n && stim[i] == 8'hFF) i++;
          if (i >= n) done = 1;
          else begin
            m = stim[i]; i++;
            if (m == 8'hD9) begin m_fe++; mode = 0; end
            else if (m == 8'hD8) begin m_err++; m_fs++; end
            else if (m == 8'h01 || (m >= 8'hD0 && m <= 8'hD7)) begin end
            else if (m == 8'h00) begin m_err++; mode = 0; end
            else if (i + 1 >= n) done = 1;
            else begin
              len = int'(stim[i]) * 256 + int'(stim[i+1]);
              i += 2;
              if (len < 2) begin m_err++; mode = 0; end
              else if (i + len - 2 > n) done = 1;
              else begin
                if (m == 8'hC0) begin
                  if (len < 7) begin m_err++; mode = 0; end
                  else begin
                    m_hdr++;
                    m_h = {stim[i+1], stim[i+2]};
                    m_w = {stim[i+3], stim[i+4]};
                  end
                end else if (m == 8'hDA) mode = 2;
                i += len - 2;
              end
            end
          end
        end
      end else begin
        b = stim[i]; i++;
        if (b != 8'hFF) m_ecs.push_back(b);
        else begin
          while (i < n && stim[i] == 8'hFF) i++;
          if (i < n) begin
            b = stim[i]; i++;
            if (b == 8'h00) m_ecs.push_back(8'hFF);
            else if (b >= 8'hD0 && b <= 8'hD7) m_rst++;
            else if (b == 8'hD9) begin m_fe++; mode = 0; end
            else begin m_err++; mode = 0; end
          end
        end
      end
    end
    m_cnt += m_fe;
  endtask

  task automatic snap();
    b_fs = c_fs; b_fe = c_fe; b_hdr = c_hdr; b_err = c_err; b_rst0 = c_rst0; b_rst1 = c_rst1;
    b_clash = c_clash; b_diff = c_diff; b_g0 = got0.size(); b_g1 = got1.size();
  endtask

  task automatic check_scn(input string tag);
    chk({tag, ".ecs_n0"}, 64'(got0.size() - b_g0), 64'(m_ecs.size()));
    chk({tag, ".ecs_n1"}, 64'(got1.size() - b_g1), 64'(m_ecs.size()));
    foreach (m_ecs[k])
      if (b_g0 + k < got0.size()) chk({tag, ".ecs_dat"}, 64'(got0[b_g0 + k]), 64'(m_ecs[k]));
    chk({tag, ".fs"}, 64'(c_fs - b_fs), 64'(m_fs));
    chk({tag, ".fe"}, 64'(c_fe - b_fe), 64'(m_fe));
    chk({tag, ".hdr"}, 64'(c_hdr - b_hdr), 64'(m_hdr));
    chk({tag, ".err"}, 64'(c_err - b_err), 64'(m_err));
    chk({tag, ".rst0"}, 64'(c_rst0 - b_rst0), 64'd0);
    chk({tag, ".rst1"}, 64'(c_rst1 - b_rst1), 64'(m_rst));
    chk({tag, ".width"}, 64'(w0), 64'(m_w));
    chk({tag, ".height"}, 64'(h0), 64'(m_h));
    chk({tag, ".fcnt16"}, 64'(fc0), 64'(m_cnt % 65536));
    chk({tag, ".fcnt2"}, 64'(fc1), 64'(m_cnt % 4));
    chk({tag, ".err_fe_clash"}, 64'(c_clash - b_clash), 64'd0);
    chk({tag, ".inst_diff"}, 64'(c_diff - b_diff), 64'd0);
  endtask

  task automatic scenario(input string tag, input int gmax);
    snap();
    run_model();
    play(gmax);
    flush();
    check_scn(tag);
  endtask

  task automatic p(input u8 b);
    stim.push_back(b);
  endtask

  task automatic p_soi();
    p(8'hFF); p(8'hD8);
  endtask

  task automatic p_eoi();
    p(8'hFF); p(8'hD9);
  endtask

  task automatic p_sof(input logic [15:0] h, input logic [15:0] w);
    u8 comps[9] = '{8'h01, 8'h22, 8'h00, 8'h02, 8'h11, 8'h01, 8'h03, 8'h11, 8'h01};
    p(8'hFF); p(8'hC0); p(8'h00); p(8'h11); p(8'h08);
    p(h[15:8]); p(h[7:0]); p(w[15:8]); p(w[7:0]); p(8'h03);
    foreach (comps[k]) p(comps[k]);
  endtask

  task automatic p_sos();
    u8 body[10] = '{8'h03, 8'h01, 8'h00, 8'h02, 8'h11, 8'h03, 8'h11, 8'h00, 8'h3F, 8'h00};
    p(8'hFF); p(8'hDA); p(8'h00); p(8'h0C);
    foreach (body[k]) p(body[k]);
  endtask

  task automatic p_seg_rand(input u8 code, input int len);
    p(8'hFF); p(code); p(u8'(len >> 8)); p(u8'(len));
    repeat (len - 2) p(u8'($urandom));
  endtask

  task automatic p_hdr_frame(input logic [15:0] h, input logic [15:0] w);
    p_soi(); p_sof(h, w); p_sos();
  endtask

  initial begin
    do_reset();
    chk("rst.ecs_valid", 64'(e0_v), 64'd0);
    chk("rst.ecs_data", 64'(e0_d), 64'd0);
    chk("rst.ecs_rst", 64'(r1), 64'd0);
    chk("rst.frame_start", 64'(fs0), 64'd0);
    chk("rst.frame_end", 64'(fe0), 64'd0);
    chk("rst.hdr_valid", 64'(hv0), 64'd0);
    chk("rst.err", 64'(er0), 64'd0);
    chk("rst.width", 64'(w0), 64'd0);
    chk("rst.height", 64'(h0), 64'd0);
    chk("rst.frame_cnt", 64'(fc0), 64'd0);

    // Header path, back to back
    stim.delete();
    p_hdr_frame(16'd360, 16'd640); p(8'h12); p(8'h34); p_eoi();
    scenario("hdr", 0);
    chk("hdr.width_const", 64'(w0), 64'd640);
    chk("hdr.height_const", 64'(h0), 64'd360);
    chk("hdr.byte0_const", 64'(got0[b_g0]), 64'h12);
    chk("hdr.byte1_const", 64'(got0[b_g0 + 1]), 64'h34);
    chk("hdr.fcnt_const", 64'(fc0), 64'd1);

    // Same stream with idle gaps between every byte
    do_reset();
    scenario("gaps", 3);

    // Byte unstuffing
    do_reset();
    stim.delete();
    p_hdr_frame(16'd360, 16'd640);
    p(8'hAB); p(8'hFF); p(8'h00); p(8'hCD); p(8'hFF); p(8'h00); p(8'hFF); p(8'h00);
    p_eoi();
    scenario("stuff", 0);
    begin
      u8 want[5] = '{8'hAB, 8'hFF, 8'hCD, 8'hFF, 8'hFF};
      foreach (want[k]) chk("stuff.const", 64'(got0[b_g0 + k]), 64'(want[k]));
    end

    // RSTn and fill bytes inside ECS
    do_reset();
    stim.delete();
    p_hdr_frame(16'd360, 16'd640);
    p(8'h11); p(8'hFF); p(8'hD3); p(8'h22); p(8'hFF); p(8'hFF); p(8'hFF); p(8'h00); p(8'h33);
    p_eoi();
    scenario("rstn", 0);
    chk("rstn.pulse_const", 64'(c_rst1 - b_rst1), 64'd1);
    chk("rstn.beats_const", 64'(got0.size() - b_g0), 64'd4);

    // Bad segment length: err, back to HUNT, trailing EOI ignored
    do_reset();
    stim.delete();
    p_soi(); p(8'hFF); p(8'hC4); p(8'h00); p(8'h01); p_eoi();
    scenario("badlen", 0);
    chk("badlen.fe_const", 64'(c_fe - b_fe), 64'd0);

    // Bad marker inside ECS, then a complete new frame
    do_reset();
    stim.delete();
    p_hdr_frame(16'd100, 16'd200); p(8'h11); p(8'hFF); p(8'h5A);
    p_hdr_frame(16'd360, 16'd640); p(8'h12); p(8'h34); p_eoi();
    scenario("ecs_err", 0);

    // Frame counter wrap on the 2-bit instance
    do_reset();
    stim.delete();
    repeat (5) begin p_soi(); p_eoi(); end
    scenario("wrap", 0);

    // Reset during ECS, then replay a full frame
    do_reset();
    stim.delete();
    p_hdr_frame(16'd50, 16'd100); p(8'h55); p(8'h66);
    play(0);
    flush();
    chk("midrst.width_before", 64'(w0), 64'd100);
    snap();
    do_reset();
    chk("midrst.width_cleared", 64'(w0), 64'd0);
    stim.delete();
    p_hdr_frame(16'd360, 16'd640); p(8'h12); p(8'h34); p_eoi();
    run_model();
    play(0);
    flush();
    check_scn("midrst");

    // Output latency: plain byte, then a stuffed FF
    do_reset();
    stim.delete();
    p_hdr_frame(16'd360, 16'd640);
    play(0);
    flush();
    send(8'h5C);
    chk("lat.plain_vld", 64'(e0_v), 64'd1);
    chk("lat.plain_dat", 64'(e0_d), 64'h5C);
    send(8'hFF);
    chk("lat.ff_hold", 64'(e0_v), 64'd0);
    send(8'h00);
    chk("lat.stuff_vld", 64'(e0_v), 64'd1);
    chk("lat.stuff_dat", 64'(e0_d), 64'hFF);
    send(8'hFF); send(8'hD9);
    chk("lat.fe", 64'(fe0), 64'd1);
    flush();

    // Encoder-like frames with tables, random stuffed ECS and restart markers
    for (int it = 0; it < 6; it++) begin
      do_reset();
      stim.delete();
      repeat ($urandom_range(0, 4)) p(u8'($urandom_range(0, 254)));
      p_soi();
      p_seg_rand(8'hE0, 16);
      p_seg_rand(8'hDB, 67);
      p_seg_rand(8'hC4, 31);
      p_sof(16'd360, 16'd640);
      p_sos();
      for (int k = 0; k < int'($urandom_range(20, 80)); k++) begin
        u8 v;
        v = ($urandom_range(0, 5) == 0) ? 8'hFF : u8'($urandom);
        if (v == 8'hFF && $urandom_range(0, 2) == 0) p(8'hFF);
        p(v);
        if (v == 8'hFF) p(8'h00);
        if ($urandom_range(0, 15) == 0) begin p(8'hFF); p(u8'(8'hD0 + $urandom_range(0, 7))); end
      end
      p_eoi();
      scenario("loop", it & 1);
      chk("loop.width_const", 64'(w0), 64'd640);
      chk("loop.height_const", 64'(h0), 64'd360);
      chk("loop.err_const", 64'(c_err - b_err), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mjpg_stream_parser.md
Name: mjpg_stream_parser

Overview:
- Receive-side counterpart of MJPG_ENCODER. Consumes its byte stream (jvalid/jpeg, one byte per cycle, no backpressure) and delimits frames at SOI/EOI.
- Captures width and height from the SOF0 segment and skips all header segments.
- Removes 0xFF00 byte stuffing and drops RSTn markers, delivering the entropy-coded segment (ECS) as plain bytes to a downstream decoder or a loopback checker.

Parameters:
- FRAME_CNT_W, 16, width of the completed-frame counter.
- PASS_RST, 0, if 1 then RSTn markers (FFD0-FFD7) pulse ecs_rst; if 0 they are dropped silently.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- jvalid  input  1  input byte valid
- jpeg  input  8  input JPEG byte
- ecs_valid  output  1  unstuffed ECS byte valid
- ecs_data  output  8  unstuffed ECS byte
- ecs_rst  output  1  one-cycle pulse on RSTn marker (PASS_RST=1 only)
- frame_start  output  1  one-cycle pulse, SOI accepted
- frame_end  output  1  one-cycle pulse, EOI accepted
- hdr_valid  output  1  one-cycle pulse, SOF0 segment fully consumed
- width  output  16  X from last SOF0, held
- height  output  16  Y from last SOF0, held
- err  output  1  one-cycle pulse, protocol violation
- frame_cnt  output  FRAME_CNT_W  EOIs accepted since reset; wraps

Behaviour:
- Reset: all outputs 0; width/height 0; frame_cnt 0; state HUNT. Reset mid-frame discards the frame with no frame_end and no err.
- State advances only on cycles with jvalid=1; idle cycles hold state. All outputs are registered, so each pulse appears the cycle after the accepting byte.
- HUNT: FF -> HUNT_FF; any other byte is ignored.
- HUNT_FF: D8 -> frame_start, go to MARK; FF -> stay; any other byte -> HUNT.
- MARK: expects FF, go to MARK_FF; any other byte -> err, go to HUNT.
- MARK_FF:
  - FF -> stay (fill byte).
  - D9 -> frame_end, frame_cnt+1, go to HUNT.
  - D8 -> err and frame_start (restart the frame), go to MARK.
  - 01 or D0-D7 -> MARK (standalone, no length).
  - 00 -> err, go to HUNT.
  - Any other byte -> LEN_H, latching the marker code.
- LEN_H / LEN_L: big-endian 16-bit L. If L<2 -> err, go to HUNT. If L==2 the body is empty and the segment ends immediately. Otherwise load cnt=L-2 and go to BODY.
- BODY: decrement cnt per byte; when cnt reaches 0 the segment ends.
  - SOF0 (C0) body byte indices 0-based: 1,2 = height[15:8],[7:0]; 3,4 = width[15:8],[7:0]. width/height update only at segment end, together with the hdr_valid pulse. If the SOF0 length is below 7 -> err and width/height are not updated.
  - Segment end: SOS (DA) -> ECS; all other markers -> MARK.
- ECS: non-FF byte -> ecs_valid with that byte; FF -> ECS_FF with no output.
- ECS_FF:
  - 00 -> ecs_valid with ecs_data=FF, go to ECS.
  - D0-D7 -> ecs_rst pulse if PASS_RST=1, go to ECS.
  - D9 -> frame_end, frame_cnt+1, go to HUNT.
  - FF -> stay (fill byte, no output).
  - Any other byte -> err, go to HUNT.
- Latency: a plain ECS byte appears 1 cycle after its input cycle. A stuffed FF appears 1 cycle after the 00 byte. ecs_valid never asserts outside ECS or ECS_FF.
- frame_cnt wraps from 2^FRAME_CNT_W-1 to 0.
- err never asserts in the same cycle as frame_end; it may coincide with frame_start only on the SOI-restart case.

Test Plan:
- Header path: stream FFD8, FFC0 0011 08 0168 0280 03 plus 9 component bytes, FFDA 000C plus 10 bytes, ECS 12 34, FFD9.
  - Expect frame_start once, hdr_valid once with height=360 and width=640.
  - Expect ecs_data 12 then 34, then frame_end, and frame_cnt=1.
- Stuffing: ECS bytes AB FF 00 CD FF 00 FF 00 -> ecs_data AB,FF,CD,FF,FF (5 beats); FF 00 FF 00 back-to-back yields two FF beats.
- Markers in ECS: FFD3 inside ECS.
  - PASS_RST=0: no ecs output, parsing continues.
  - PASS_RST=1: one ecs_rst pulse.
  - FF FF FF 00 -> single FF beat.
- Errors:
  - FFC4 0001 -> err, then HUNT; no frame_end follows.
  - FF 5A inside ECS -> err; a subsequent FFD8 starts a new frame.
- Gaps and reset: insert 3 random idle cycles between every byte of the header-path stream -> identical outputs. Assert rst during ECS, then replay the full frame -> frame_cnt=1 and width/height reflect only the second SOF0.
- Loopback: feed MJPG_ENCODER output for a 640x360 frame -> width=640, height=360, exactly one frame_start/frame_end pair, err never asserted.
